// File: rtl/uart_param.sv
// ---------------------------------------------------------------------------
// uart_param -- parametrised full-duplex UART.
//
// Transmitter serialises DATA_BITS words LSB first with one start bit and
// STOP_BITS stop bits. Receiver synchronises rx, rejects start glitches by
// re-checking the line at the start-bit midpoint, samples every data bit at
// its midpoint and reports framing errors and overruns.
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> a parity bit follows the data (even, or odd if PARITY_ODD),
//                the receiver checks it and reports parity_err.
//   undefined -> no parity state in either FSM, parity_err tied low.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active high
//   data_send      word to transmit, captured when wr_en is accepted
//   wr_en          transmit request, accepted only while tx_busy = 0
//   tx             serial output, idle high
//   tx_busy        transmitter occupied
//   rx             serial input, asynchronous to clk
//   rdy            received word valid, sticky until rdy_clr
//   rdy_clr        one-cycle pulse clearing rdy and overrun
//   received_data  last received word
//   frame_err      stop bit of the last word sampled low
//   parity_err     parity of the last word mismatched
//   overrun        a word completed while rdy was still set (sticky)
// ---------------------------------------------------------------------------
module uart_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_send,
    input  logic                 wr_en,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] received_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_busy_q, tx_busy_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (wr_en) begin
                    tx_shift_d = data_send;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^data_send) ^ PAR_ODD;
`endif
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        tx_d       = tx_par_q;
                        tx_state_d = TX_PARITY;
`else
                        tx_d       = 1'b1;
                        tx_stop_d  = 1'b0;
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        // Shift so the next bit to send always sits at index 0.
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = 1'b1;
                    tx_stop_d  = 1'b0;
                    tx_state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_stop_q == STOP_LAST) begin
                        // wr_en in this cycle is seen by TX_STOP, so it is ignored.
                        tx_busy_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // NOTE: no memories here; every register including the datapath is reset so outputs are defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rdy_q, rdy_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;
        rdy_d       = rdy_q;
        overrun_d   = overrun_q;
`ifdef UART_PARITY_EN
        rx_par_d     = rx_par_q;
        parity_err_d = parity_err_q;
`endif
        // A completion below overrides this clear, so a coincident word is not lost.
        if (rdy_clr) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // Line back high at mid start bit: a glitch, drop it silently.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d    = '0;
                    data_d      = rx_shift_q;
                    frame_err_d = ~rx_sync_q;
`ifdef UART_PARITY_EN
                    parity_err_d = (^rx_shift_q) ^ PAR_ODD ^ rx_par_q;
`endif
                    rdy_d = 1'b1;
                    if (rdy_q && !rdy_clr) overrun_d = 1'b1;
                    // A low stop bit may be a break: wait for idle before hunting a new start.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            rdy_q       <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            rdy_q       <= rdy_d;
            overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rdy           = rdy_q;
    assign received_data = data_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
`ifdef UART_PARITY_EN
    assign parity_err    = parity_err_q;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param.sv
// ---------------------------------------------------------------------------
// tb_uart_param -- directed bench for uart_param.
// Instance dut (CLKS_PER_BIT=16): rx driven by the bench, tx observed.
// Instance lb  (CLKS_PER_BIT=4):  tx looped back to rx.
// ---------------------------------------------------------------------------
module tb_uart_param;

    localparam int CPB    = 16;
    localparam int CPB_LB = 4;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = 10 + (PAR_EN ? 1 : 0);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_send, received_data;
    logic       wr_en, tx, tx_busy, rx, rdy, rdy_clr, frame_err, parity_err, overrun;
    logic [7:0] lb_data_send, lb_received_data;
    logic       lb_wr_en, lb_tx, lb_tx_busy, lb_rdy, lb_rdy_clr, lb_frame_err, lb_parity_err, lb_overrun;

    always #5 clk = ~clk;

    uart_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .data_send(data_send), .wr_en(wr_en), .tx(tx), .tx_busy(tx_busy),
        .rx(rx), .rdy(rdy), .rdy_clr(rdy_clr), .received_data(received_data),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    uart_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB_LB), .STOP_BITS(1), .PARITY_ODD(0)) lb (
        .clk(clk), .rst(rst), .data_send(lb_data_send), .wr_en(lb_wr_en), .tx(lb_tx), .tx_busy(lb_tx_busy),
        .rx(lb_tx), .rdy(lb_rdy), .rdy_clr(lb_rdy_clr), .received_data(lb_received_data),
        .frame_err(lb_frame_err), .parity_err(lb_parity_err), .overrun(lb_overrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame onto dut.rx; par_val is only sent when parity is enabled.
    task automatic send_rx(input logic [7:0] w, input logic stop_val, input logic par_val);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = w[i];
            tick(CPB);
        end
        if (PAR_EN) begin
            rx = par_val;
            tick(CPB);
        end
        rx = stop_val;
        tick(CPB);
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (!rdy && n < 4 * CPB) begin
            tick(1);
            n++;
        end
        check({name, " rdy"}, rdy, 1);
    endtask

    task automatic clear_rdy(input string name);
        rdy_clr = 1'b1;
        tick(1);
        rdy_clr = 1'b0;
        check({name, " rdy cleared"}, rdy, 0);
    endtask

    // Called one cycle after tx_busy rose. Samples tx mid-bit until tx_busy falls.
    // A second request with poke_data is made while busy; with chain set, a new
    // request is raised in the cycle whose edge ends the last stop bit.
    task automatic tx_capture(input logic [7:0] poke_data, input bit chain, input logic [7:0] chain_data,
                              output logic [7:0] got, output logic [1:0] framing, output int cycles);
        int c = 0;
        got = '0;
        framing = '0;
        while (tx_busy && c < FRAME_BITS * CPB + 20) begin
            if (c == 3 * CPB) begin
                wr_en = 1'b1;
                data_send = poke_data;
            end
            if (c == 3 * CPB + 1) wr_en = 1'b0;
            if (chain && c == FRAME_BITS * CPB - 1) begin
                wr_en = 1'b1;
                data_send = chain_data;
            end
            tick(1);
            c++;
            if (c % CPB == CPB / 2) begin
                int k = c / CPB;
                if (k == 0) framing[0] = ~tx;
                if (k >= 1 && k <= 8) got[k-1] = tx;
                if (k == FRAME_BITS - 1) framing[1] = tx;
            end
        end
        cycles = c;
    endtask

    typedef struct {
        logic [7:0] word;
        logic       stop_val;
        logic       par_flip;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } rx_vec_t;

    rx_vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        logic [1:0] framing;
        int cycles;
        int lows;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, PAR_EN};
        vecs[8] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};

        rst = 1'b1;
        wr_en = 1'b0; data_send = '0; rx = 1'b1; rdy_clr = 1'b0;
        lb_wr_en = 1'b0; lb_data_send = '0; lb_rdy_clr = 1'b0;
        #23;
        check("reset tx", tx, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset rdy", rdy, 0);
        check("reset received_data", received_data, 0);
        check("reset flags", {frame_err, parity_err, overrun}, 0);
        check("reset lb tx", lb_tx, 1);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Loopback: every word 0x00..0xFF must come back clean.
        for (int w = 0; w < 256; w++) begin
            int n = 0;
            while (lb_tx_busy && n < 20 * CPB_LB) begin
                tick(1);
                n++;
            end
            lb_data_send = 8'(w);
            lb_wr_en = 1'b1;
            tick(1);
            lb_wr_en = 1'b0;
            n = 0;
            while (!lb_rdy && n < 20 * CPB_LB) begin
                tick(1);
                n++;
            end
            check("loopback word", {lb_rdy, lb_frame_err, lb_parity_err, lb_overrun, lb_received_data},
                  {4'b1000, 8'(w)});
            lb_rdy_clr = 1'b1;
            tick(1);
            lb_rdy_clr = 1'b0;
        end

        // Table-driven receive vectors.
        for (int i = 0; i < 9; i++) begin
            send_rx(vecs[i].word, vecs[i].stop_val, (^vecs[i].word) ^ vecs[i].par_flip);
            wait_rdy("vector");
            check("vector data", received_data, vecs[i].exp_data);
            check("vector frame_err", frame_err, vecs[i].exp_ferr);
            check("vector parity_err", parity_err, vecs[i].exp_perr);
            check("vector overrun", overrun, 0);
            clear_rdy("vector");
            rx = 1'b1;
            tick(2 * CPB);
        end

        // One-cycle start glitch is rejected, a following frame is received.
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch no rdy", rdy, 0);
        send_rx(8'hA5, 1'b1, ^8'hA5);
        wait_rdy("after glitch");
        check("after glitch data", received_data, 8'hA5);
        check("after glitch frame_err", frame_err, 0);
        clear_rdy("after glitch");

        // Frame error with a held-low line, then recovery after rx goes high.
        send_rx(8'h3C, 1'b0, ^8'h3C);
        wait_rdy("break");
        check("break data", received_data, 8'h3C);
        check("break frame_err", frame_err, 1);
        clear_rdy("break");
        tick(3 * CPB);
        check("break held no rdy", rdy, 0);
        rx = 1'b1;
        tick(CPB);
        send_rx(8'h96, 1'b1, ^8'h96);
        wait_rdy("post break");
        check("post break data", received_data, 8'h96);
        check("post break frame_err", frame_err, 0);
        clear_rdy("post break");
        tick(2 * CPB);

        // Overrun: two words without rdy_clr.
        send_rx(8'h11, 1'b1, ^8'h11);
        send_rx(8'h22, 1'b1, ^8'h22);
        wait_rdy("overrun");
        check("overrun data", received_data, 8'h22);
        check("overrun flag", overrun, 1);
        rdy_clr = 1'b1;
        tick(1);
        rdy_clr = 1'b0;
        check("overrun cleared rdy", rdy, 0);
        check("overrun cleared flag", overrun, 0);

        // Transmit timing, ignored request while busy, back-to-back boundary.
        data_send = 8'h5A;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        check("tx start busy", tx_busy, 1);
        check("tx start bit", tx, 0);
        tx_capture(8'hFF, 1'b1, 8'hC3, got, framing, cycles);
        check("tx frame length", cycles, FRAME_BITS * CPB);
        check("tx data 5A", got, 8'h5A);
        check("tx framing 5A", framing, 2'b11);
        check("tx busy falls", tx_busy, 0);
        tick(1);
        wr_en = 1'b0;
        check("tx chained busy", tx_busy, 1);
        check("tx chained start", tx, 0);
        tx_capture(8'h00, 1'b0, 8'h00, got, framing, cycles);
        check("tx data C3", got, 8'hC3);
        check("tx framing C3", framing, 2'b11);
        lows = 0;
        for (int i = 0; i < 2 * FRAME_BITS * CPB; i++) begin
            tick(1);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("tx no extra frame", lows, 0);

        // Reset in the middle of data bit 3.
        data_send = 8'h96;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        tick(4 * CPB + 5);
        check("pre-reset busy", tx_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid-tx reset tx", tx, 1);
        check("mid-tx reset busy", tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        data_send = 8'h3C;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        tx_capture(8'hFF, 1'b0, 8'h00, got, framing, cycles);
        check("post-reset tx data", got, 8'h3C);
        check("post-reset tx length", cycles, FRAME_BITS * CPB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
